// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for the F-E-W MIPS core.
// One shift-add or restoring shift-subtract step per cycle, then a sign fix-up cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_rd,
    output logic             busy,
    output logic             done,
    output logic             stall_EX,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hacc_q, hacc_d;
    logic [WIDTH-1:0]   lacc_q, lacc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               mul_q, mul_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               divz_q, divz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               sgn;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rsh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        sgn   = ~op[0];
        abs_a = (sgn && a[WIDTH-1]) ? -a : a;
        abs_b = (sgn && b[WIDTH-1]) ? -b : b;
        sum   = {1'b0, hacc_q} + {1'b0, opnd_q};
        rsh   = {hacc_q, lacc_q[WIDTH-1]};
        trial = rsh - {1'b0, opnd_q};
        prod  = {hacc_q, lacc_q};
        prod_fix = negq_q ? -prod : prod;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hacc_d  = hacc_q;
        lacc_d  = lacc_q;
        opnd_d  = opnd_q;
        mul_d   = mul_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        divz_d  = divz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            state_d = RUN;
                            cnt_d   = '0;
                            hacc_d  = '0;
                            lacc_d  = abs_a;
                            opnd_d  = abs_b;
                            mul_d   = ~op[1];
                            negq_d  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                            negr_d  = sgn & a[WIDTH-1];
                            divz_d  = (b == '0);
                        end
                        3'b100: hi_d = a;
                        3'b101: lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (mul_q) begin
                    if (lacc_q[0]) begin
                        {hacc_d, lacc_d} = {sum, lacc_q[WIDTH-1:1]};
                    end else begin
                        {hacc_d, lacc_d} = {1'b0, hacc_q, lacc_q[WIDTH-1:1]};
                    end
                end else if (!trial[WIDTH]) begin
                    hacc_d = trial[WIDTH-1:0];
                    lacc_d = {lacc_q[WIDTH-2:0], 1'b1};
                end else begin
                    hacc_d = rsh[WIDTH-1:0];
                    lacc_d = {lacc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (mul_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else begin
                    // remainder already equals the dividend when dividing by zero
                    hi_d = negr_q ? -hacc_q : hacc_q;
                    lo_d = divz_q ? '1 : (negq_q ? -lacc_q : lacc_q);
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hacc_q  <= '0;
            lacc_q  <= '0;
            opnd_q  <= '0;
            mul_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            divz_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hacc_q  <= hacc_d;
            lacc_q  <= lacc_d;
            opnd_q  <= opnd_d;
            mul_q   <= mul_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            divz_q  <= divz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign stall_EX = busy_q & (start | hilo_rd);
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
